// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial arithmetic engines.
// The state encodings are fixed so that a future serial adder can reuse them.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B - B0 engine. It takes one operand pair through a valid/ready
// handshake and processes one bit per clock, LSB first, through a single
// full-subtractor cell. The difference, final borrow and signed overflow are
// returned through a second valid/ready handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             B0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  // The minuend register doubles as the difference shift register: each
  // consumed bit of A leaves at the LSB end while the new difference bit
  // enters at the MSB end.
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic             r_brw;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_last;
  logic             w_release;
  logic             w_cell_d;
  logic             w_cell_bo;
  logic             w_ovf;

  full_subtractor u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_brw),
    .d    (w_cell_d),
    .bout (w_cell_bo)
  );

  // in_ready depends only on state (and is held low during reset).
  assign in_ready  = (r_state == ST_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == LAST_BIT);
  assign w_release = r_out_valid && out_ready;
  // On the final bit the cell inputs are the operand sign bits.
  assign w_ovf     = (r_a_sr[0] ^ r_b_sr[0]) & (w_cell_d ^ r_a_sr[0]);

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments so every
    // register samples the pre-edge values of every other register.
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default is assigned first so no path leaves w_state_nxt
    // unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept)  w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:  if (w_release) w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit counter, result register and output valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) r_cnt <= '0;
        end
        ST_SHIFT: begin
          if (w_last) begin
            r_cnt       <= '0;
            r_diff      <= {w_cell_d, r_a_sr[WIDTH-1:1]};
            r_bout      <= w_cell_bo;
            r_ovf       <= w_ovf;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (w_release) r_out_valid <= 1'b0;
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  // Operand shift registers and running borrow.
  always_ff @(posedge clk) begin
    // NOTE: these datapath registers carry no reset; they are always loaded
    // on acceptance before being read, and control state alone decides
    // whether their contents are meaningful.
    if (w_accept) begin
      r_a_sr <= A;
      r_b_sr <= B;
      r_brw  <= B0;
    end else if (r_state == ST_SHIFT) begin
      r_a_sr <= {w_cell_d, r_a_sr[WIDTH-1:1]};
      r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_brw  <= w_cell_bo;
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
